// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory.
// Sub-word stores are performed as read-modify-write; illegal accesses are trapped without touching memory.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_q;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic        r_err;
    logic        w_err;
    logic [31:0] w_word_addr;

    function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] res;
        res = old;
        case (sz)
            2'b00:   res[{off, 3'b000} +: 8]     = wd[7:0];
            2'b01:   res[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: res = wd;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] data, input logic [1:0] sz,
                                                 input logic sg, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   res = {{24{sg & b[7]}}, b};
            2'b01:   res = {{16{sg & h[15]}}, h};
            default: res = data;
        endcase
        return res;
    endfunction

    assign w_word_addr = {2'b00, req_addr[31:2]};

    always_comb begin
        w_err = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
              | (w_word_addr >= 32'(MEM_WORDS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata_q <= '0;
            r_size    <= '0;
            r_signed  <= 1'b0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_size    <= req_size;
                r_signed  <= req_signed;
                r_write   <= req_write;
                r_err     <= w_err;
                r_rdata_q <= '0;
            end
            if (r_state == S_RD) begin
                r_rdata_q <= mem_readData;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err)                               w_next = S_RESP;
                    else if (req_write && req_size == 2'b10) w_next = S_WR;
                    else                                     w_next = S_RD;
                end
            end
            S_RD:    w_next = r_write ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes and response are pure state decodes so IDLE/RESP always present a quiet bus.
    always_comb begin
        req_ready     = (r_state == S_IDLE) & ~rst;
        resp_valid    = 1'b0;
        resp_error    = 1'b0;
        resp_rdata    = '0;
        mem_address   = '0;
        mem_writeData = '0;
        mem_memWrite  = 1'b0;
        mem_memRead   = 1'b0;
        case (r_state)
            S_RD: begin
                mem_memRead = 1'b1;
                mem_address = {2'b00, r_addr[31:2]};
            end
            S_WR: begin
                mem_memWrite  = 1'b1;
                mem_address   = {2'b00, r_addr[31:2]};
                mem_writeData = merge_lane(r_rdata_q, r_wdata, r_size, r_addr[1:0]);
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_error = r_err;
                if (!r_err && !r_write) begin
                    resp_rdata = extract_lane(r_rdata_q, r_size, r_signed, r_addr[1:0]);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the pipeline's MEM stage and the word-wide data memory, which writes on posedge, reads on negedge and is indexed by word address. Turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses. Sub-word stores are done as read-modify-write. Misaligned and out-of-range accesses are trapped, and the unit stalls the pipeline via req_ready while an access is in flight.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the attached data memory; word addresses >= MEM_WORDS are errors.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  pipeline presents a memory op
req_ready  out  1  unit idle and able to accept (1 only in IDLE)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  sign-extend loads (ignored for stores/word)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle pulse: op complete
resp_error  out  1  valid with resp_valid: misaligned, out-of-range or reserved size
resp_rdata  out  32  load result, valid with resp_valid (0 for stores/errors)
mem_address  out  32  word address to memory (req_addr >> 2)
mem_writeData  out  32  word write data
mem_memWrite  out  1  memory write enable
mem_memRead  out  1  memory read enable
mem_readData  in  32  memory read data (updated on negedge)

Behaviour:
- Little-endian lanes: byte k = bits [8k+7:8k]; half at addr[1] = bits [16*addr[1]+15 : 16*addr[1]].
- States: IDLE, RD, WR, RESP.
- IDLE
  - req_ready=1. On req_valid, latch the request (addr, size, signed, write, wdata).
  - Error check: size==11; half with addr[0]=1; word with addr[1:0]!=0; or (addr>>2) >= MEM_WORDS.
  - Error: go to RESP with error flag set; no memory access ever.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD
  - mem_memRead=1, mem_address=latched word address.
  - At the closing posedge, capture mem_readData into rdata_q.
  - Load: go to RESP. Sub-word store: go to WR.
- WR
  - mem_memWrite=1 for exactly one cycle.
  - mem_writeData = req_wdata for word stores; otherwise rdata_q with the addressed lane replaced by req_wdata[7:0] or [15:0].
  - Then go to RESP.
- RESP
  - resp_valid=1 for one cycle; resp_error from the latched flag.
  - resp_rdata = addressed lane, sign- or zero-extended per req_signed; full word for lw; 0 for stores/errors.
  - Then go to IDLE; a new request can be accepted the following cycle.
- Memory strobes are decoded from state only. mem_memRead and mem_memWrite are never both 1. In IDLE and RESP, mem_address=0, mem_writeData=0, and both strobes are 0.
- Latency from accept edge to resp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Request inputs are ignored outside IDLE.
- Reset (async): state=IDLE and all latched registers=0 immediately. Outputs go to: req_ready=1 once rst deasserts (0 while rst=1), resp_valid=0, resp_error=0, resp_rdata=0, mem_* outputs=0.
- Reset mid-operation abandons the op: no write is issued after rst rises, and no resp_valid is produced for the aborted op.

Test Plan:
- Preload word 4 = 0x876543A1. lb 0x10 signed -> resp_rdata 0xFFFFFFA1 at 2 cycles; lbu 0x13 -> 0x00000087; one mem_memRead pulse each, no mem_memWrite.
- Same preload. lh 0x12 signed -> 0xFFFF8765; lhu 0x10 -> 0x000043A1; lw 0x10 -> 0x876543A1.
- sb 0x11 wdata 0x000000CC -> RD then WR, writeData 0x8765CCA1, resp_valid at cycle 3; subsequent lw 0x10 -> 0x8765CCA1.
- sh 0x11, lw 0x12, lb with size=11, and lw 0x1000 (word 1024) -> each gives resp_error=1 at 1 cycle, resp_rdata=0, zero mem_memRead/mem_memWrite pulses.
- sw 0x14 0xDEADBEEF -> single WR cycle, no RD, resp at 2 cycles. Back-to-back lw 0x14 issued the cycle after RESP -> 0xDEADBEEF. req_ready=0 throughout every in-flight op.
- sh 0x10 0x1234 with rst pulsed during RD -> mem_memWrite never asserted, no resp_valid, req_ready=1 after release, word 4 unchanged.
